// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU pipeline blocks.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        START,
        REQ,
        HOLD,
        CHECK,
        HALT,
        FAULT
    } ifetch_state_t;

    localparam logic [31:0] RESET_VECTOR      = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/mips_cpu_ifetch.sv
// Instruction fetch: reads the word at pc into ir, hands it to decode, and
// strobes pc_en once per consumed instruction. Detects halt, misalignment, timeout.
module mips_cpu_ifetch
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEFAULT,
    parameter int          MAX_WAIT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_en,
    output logic [31:0] instr_address,
    output logic        instr_read,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [25:0] j_instr_addr,
    output logic [15:0] i_instr_addr,
    output logic        active,
    output logic        fetch_fault
);

    localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    ifetch_state_t    state, state_nx;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;

    // The current wait cycle is the MAX_WAIT-th one when the count already holds MAX_WAIT-1.
    assign timeout = (wait_cnt >= WAIT_LAST);

    always_comb begin
        state_nx   = state;
        instr_read = 1'b0;
        ir_valid   = 1'b0;
        pc_en      = 1'b0;
        case (state)
            START, CHECK: begin
                if (pc == HALT_ADDR)
                    state_nx = HALT;
                else if (pc[1:0] != 2'b00)
                    state_nx = FAULT;
                else
                    state_nx = REQ;
            end
            REQ: begin
                instr_read = 1'b1;
                if (!instr_waitrequest)
                    state_nx = HOLD;
                else if (timeout)
                    state_nx = FAULT;
            end
            HOLD: begin
                ir_valid = 1'b1;
                if (ir_ready) begin
                    pc_en    = 1'b1;
                    state_nx = CHECK;
                end
            end
            HALT, FAULT: state_nx = state;
            default:     state_nx = FAULT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= START;
            ir       <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == REQ) begin
                if (!instr_waitrequest) begin
                    ir       <= instr_readdata;
                    wait_cnt <= '0;
                end else if (wait_cnt != {CNT_W{1'b1}}) begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign instr_address = pc;
    assign j_instr_addr  = ir[25:0];
    assign i_instr_addr  = ir[15:0];
    assign active        = !((state == HALT) || (state == FAULT));
    assign fetch_fault   = (state == FAULT);

endmodule
